uart_cmd_parser: RTL and testbench
==================================

# uart_cmd_parser

Byte-level command parser between the UART FIFO loopback stage and the dual watch core. It consumes received bytes, each qualified by a one-cycle valid strobe. Single-character commands become one-cycle button/toggle strobes. A multi-byte set-time sentence, `T` followed by six decimal digits and a terminator, becomes a validated hour/min/sec load pulse. Malformed sentences are discarded with an error pulse, and stalled sentences are aborted by an inactivity timeout.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 100_000_000: idle cycles allowed between bytes of a set-time sentence (1 s at 100 MHz); must be ≥ 2.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `rx_data`  in  8  received byte, valid only while `rx_valid`=1.
- `rx_valid`  in  1  one-cycle byte strobe from the FIFO loopback stage.
- `cmd_btn`  out  4  one-cycle strobes {R, L, U, D}.
- `cmd_tog`  out  3  one-cycle mode-toggle strobes {fmt, wtch, calib}.
- `set_valid`  out  1  one-cycle pulse; the `set_*` outputs below hold a checked time.
- `set_hour`  out  5  0–23.
- `set_min`  out  6  0–59.
- `set_sec`  out  6  0–59.
- `err`  out  1  one-cycle pulse on a malformed or timed-out sentence.

## Operation
- States: IDLE, DIGIT (index 0–5), TERM.
- Behaviour in IDLE, on `rx_valid`:
  - `r` (0x72), `s` (0x73), `R` (0x52) → `cmd_btn[3]`.
  - `L` (0x4C) → `cmd_btn[2]`.
  - `+` (0x2B) → `cmd_btn[1]`.
  - `-` (0x2D) → `cmd_btn[0]`.
  - `F` (0x46) → `cmd_tog[2]`.
  - `M` (0x4D) → `cmd_tog[1]`.
  - `C` (0x43) → `cmd_tog[0]`.
  - `T` (0x54) → DIGIT, index 0.
  - Any other byte is ignored silently, with no `err`.
  - `c` (clear) maps to `cmd_btn[2]` (L), the core's clear button.
- Behaviour in DIGIT, on `rx_valid`:
  - `0`–`9` (0x30–0x39): store `rx_data - 8'h30` in digit register[index] and increment index.
  - After index 5 is stored → TERM.
  - Any non-digit byte, including command characters, → `err`, IDLE. The byte is not re-decoded as a command.
- Behaviour in TERM, on `rx_valid`:
  - CR (0x0D) or LF (0x0A): compute hour = d0·10+d1, min = d2·10+d3, sec = d4·10+d5 in 7-bit arithmetic (max 99).
  - If hour ≤ 23, min ≤ 59 and sec ≤ 59: pulse `set_valid`. Otherwise pulse `err`. Either way → IDLE.
  - Any other byte → `err`, IDLE.
- `set_hour`, `set_min` and `set_sec` are registered. They update only together with `set_valid` and hold between pulses.
- Timeout:
  - The counter clears on every `rx_valid` and while in IDLE.
  - When in DIGIT/TERM and the count reaches `TIMEOUT_CYC-1` with no byte: `err`, IDLE.
- At most one output strobe bit is set in any cycle.

## Timing
- Reset values:
  - `cmd_btn` = 0, `cmd_tog` = 0, `set_valid` = 0, `err` = 0.
  - `set_hour` = 0, `set_min` = 0, `set_sec` = 0.
  - State = IDLE, index = 0, timeout counter = 0.
- All outputs are registered. A strobe appears the cycle after the `rx_valid` cycle (latency 1) and lasts exactly one cycle.
- `set_valid` appears one cycle after the terminator byte is accepted.
- Back-to-back `rx_valid` on consecutive cycles must be accepted. Each byte yields its own strobe.
- `rx_valid` in the same cycle as timeout expiry: the byte wins. It is processed normally and the counter clears.
- `rst` asserted mid-sentence: the partial sentence is dropped, no `err` pulse. A byte presented during the `rst` cycle is ignored.
- A second `T` inside DIGIT is a non-digit, so it gives `err` and IDLE. The sender must resend `T`.

## Structure
- Shared package `uart_cmd_pkg`:
  - ASCII localparams (CMD_RUN, CMD_STOP, CMD_CLEAR, CMD_LEFT, CMD_RIGHT, CMD_UP, CMD_DOWN, CMD_FMT, CMD_WTCH, CMD_CALIB, CMD_SETT, ASCII_CR, ASCII_LF).
  - State encodings.
  - Strobe bit indices for `cmd_btn` and `cmd_tog`.
- One sub-module, `cmd_timeout_cnt`: width `$clog2(TIMEOUT_CYC)`, inputs clr/en, output expire pulse.
- The top-level ORs `cmd_btn` with debounced buttons and routes `cmd_tog` into the mode toggles.

## Test plan
- Reset, then bytes `r`, `L`, `+`, `-`, `F`, `M`, `C` spaced 3 cycles apart → exactly one strobe each, 1 cycle after its `rx_valid`, in order `cmd_btn` 1000, 0100, 0010, 0001, `cmd_tog` 100, 010, 001.
- `T`,`1`,`2`,`3`,`4`,`5`,`6`,CR back-to-back → `set_valid` one cycle after CR with hour = 12, min = 34, sec = 56. No `err`.
- `T`,`2`,`4`,`0`,`0`,`0`,`0`,LF → `err`, no `set_valid`, `set_*` unchanged. Also `T`,`1`,`x` → `err` one cycle after `x`, then `r` → `cmd_btn[3]`.
- With `TIMEOUT_CYC`=16: `T`,`0`,`9` then silence → `err` after 15 idle cycles. Repeat with a byte arriving on cycle 15 → no `err`.
- `T`,`0`,`1`, then `rst` for 1 cycle, then `2`,`3`,CR → no `set_valid`, no `err`. Bytes are ignored and no strobes fire.
- Byte `z` in IDLE → no output activity.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_pkg
//  Purpose  : Shared constants for the UART command parser. Contains the
//             ASCII command codes, the parser states, the strobe bit
//             positions and a two-digit decimal helper.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

    // Command characters recognised in IDLE
    localparam logic [7:0] CMD_RUN   = 8'h72;  // 'r'
    localparam logic [7:0] CMD_STOP  = 8'h73;  // 's'
    localparam logic [7:0] CMD_CLEAR = 8'h63;  // 'c'
    localparam logic [7:0] CMD_LEFT  = 8'h4C;  // 'L'
    localparam logic [7:0] CMD_RIGHT = 8'h52;  // 'R'
    localparam logic [7:0] CMD_UP    = 8'h2B;  // '+'
    localparam logic [7:0] CMD_DOWN  = 8'h2D;  // '-'
    localparam logic [7:0] CMD_FMT   = 8'h46;  // 'F'
    localparam logic [7:0] CMD_WTCH  = 8'h4D;  // 'M'
    localparam logic [7:0] CMD_CALIB = 8'h43;  // 'C'
    localparam logic [7:0] CMD_SETT  = 8'h54;  // 'T'
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_0   = 8'h30;
    localparam logic [7:0] ASCII_9   = 8'h39;

    // Parser states, explicitly encoded
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIGIT = 2'd1,
        ST_TERM  = 2'd2
    } state_t;

    // cmd_btn bit positions {R, L, U, D}
    localparam int unsigned BTN_R = 3;
    localparam int unsigned BTN_L = 2;
    localparam int unsigned BTN_U = 1;
    localparam int unsigned BTN_D = 0;

    // cmd_tog bit positions {fmt, wtch, calib}
    localparam int unsigned TOG_FMT   = 2;
    localparam int unsigned TOG_WTCH  = 1;
    localparam int unsigned TOG_CALIB = 0;

    // tens*10 + units in 7-bit arithmetic (max 99)
    function automatic logic [6:0] two_digit(input logic [3:0] tens,
                                             input logic [3:0] units);
        return 7'(tens) * 7'd10 + 7'(units);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_timeout_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : cmd_timeout_cnt
//  Purpose  : Inactivity counter for set-time sentences. Clears on clr.
//             Counts while en is high. Flags expire combinationally in the
//             cycle that the count sits at TIMEOUT_CYC-1 and no clear is
//             pending.
//  Revision : 1.0 - initial release
// ============================================================================
module cmd_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned            c_cnt_w = $clog2(TIMEOUT_CYC);
    localparam logic [c_cnt_w-1:0]     c_last  = c_cnt_w'(TIMEOUT_CYC - 1);
    localparam logic [c_cnt_w-1:0]     c_one   = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_cnt;

    // Idle-cycle counter: cleared by traffic or by leaving the sentence
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + c_one;
        end
    end

    // A byte in the expiry cycle suppresses the timeout
    assign expire = en && !clr && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_parser
//  Purpose  : Turns received UART bytes into one-cycle button and toggle
//             strobes. Also decodes "T" + six digits + CR/LF into a range-
//             checked hour/min/sec load. Bad or stalled sentences raise err.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [3:0] cmd_btn,
    output logic [2:0] cmd_tog,
    output logic       set_valid,
    output logic [4:0] set_hour,
    output logic [5:0] set_min,
    output logic [5:0] set_sec,
    output logic       err
);

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_idx, w_idx_nxt;
    logic [3:0]  r_digit [0:5];
    logic        w_digit_we;
    logic        w_is_digit;
    logic [3:0]  w_digit_val;
    logic        w_is_term;
    logic        w_expire;
    logic [6:0]  w_hour, w_min, w_sec;
    logic        w_time_ok;

    logic [3:0]  w_btn_nxt;
    logic [2:0]  w_tog_nxt;
    logic        w_set_nxt;
    logic        w_err_nxt;

    logic [3:0]  r_cmd_btn;
    logic [2:0]  r_cmd_tog;
    logic        r_set_valid;
    logic        r_err;
    logic [4:0]  r_set_hour;
    logic [5:0]  r_set_min;
    logic [5:0]  r_set_sec;

    assign w_is_digit  = (rx_data >= ASCII_0) && (rx_data <= ASCII_9);
    // For 0x30..0x39 the low nibble equals rx_data - 0x30
    assign w_digit_val = rx_data[3:0];
    assign w_is_term   = (rx_data == ASCII_CR) || (rx_data == ASCII_LF);

    assign w_hour    = two_digit(r_digit[0], r_digit[1]);
    assign w_min     = two_digit(r_digit[2], r_digit[3]);
    assign w_sec     = two_digit(r_digit[4], r_digit[5]);
    assign w_time_ok = (w_hour <= 7'd23) && (w_min <= 7'd59) && (w_sec <= 7'd59);

    cmd_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (rx_valid || (r_state == ST_IDLE)),
        .en     (r_state != ST_IDLE),
        .expire (w_expire)
    );

    // Next-state and strobe decode; a byte always takes priority over expiry
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_digit_we  = 1'b0;
        w_btn_nxt   = '0;
        w_tog_nxt   = '0;
        w_set_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_idx_nxt = 3'd0;
                if (rx_valid) begin
                    case (rx_data)
                        CMD_RUN, CMD_STOP, CMD_RIGHT: w_btn_nxt[BTN_R]     = 1'b1;
                        CMD_LEFT, CMD_CLEAR:          w_btn_nxt[BTN_L]     = 1'b1;
                        CMD_UP:                       w_btn_nxt[BTN_U]     = 1'b1;
                        CMD_DOWN:                     w_btn_nxt[BTN_D]     = 1'b1;
                        CMD_FMT:                      w_tog_nxt[TOG_FMT]   = 1'b1;
                        CMD_WTCH:                     w_tog_nxt[TOG_WTCH]  = 1'b1;
                        CMD_CALIB:                    w_tog_nxt[TOG_CALIB] = 1'b1;
                        CMD_SETT:                     w_state_nxt          = ST_DIGIT;
                        default: ;
                    endcase
                end
            end
            ST_DIGIT: begin
                if (rx_valid) begin
                    if (w_is_digit) begin
                        w_digit_we = 1'b1;
                        if (r_idx == 3'd5) begin
                            w_state_nxt = ST_TERM;
                            w_idx_nxt   = 3'd0;
                        end else begin
                            w_idx_nxt = r_idx + 3'd1;
                        end
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_IDLE;
                        w_idx_nxt   = 3'd0;
                    end
                end else if (w_expire) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = 3'd0;
                end
            end
            ST_TERM: begin
                if (rx_valid) begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = 3'd0;
                    if (w_is_term && w_time_ok) begin
                        w_set_nxt = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end else if (w_expire) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = 3'd0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = 3'd0;
            end
        endcase
    end

    // State and digit-index register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Digit capture for the set-time sentence
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 6; i++) begin
                r_digit[i] <= 4'd0;
            end
        end else if (w_digit_we) begin
            r_digit[r_idx] <= w_digit_val;
        end
    end

    // Registered strobes, plus the time fields that load only with set_valid
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_btn   <= '0;
            r_cmd_tog   <= '0;
            r_set_valid <= 1'b0;
            r_err       <= 1'b0;
            r_set_hour  <= '0;
            r_set_min   <= '0;
            r_set_sec   <= '0;
        end else begin
            r_cmd_btn   <= w_btn_nxt;
            r_cmd_tog   <= w_tog_nxt;
            r_set_valid <= w_set_nxt;
            r_err       <= w_err_nxt;
            if (w_set_nxt) begin
                r_set_hour <= w_hour[4:0];
                r_set_min  <= w_min[5:0];
                r_set_sec  <= w_sec[5:0];
            end
        end
    end

    assign cmd_btn   = r_cmd_btn;
    assign cmd_tog   = r_cmd_tog;
    assign set_valid = r_set_valid;
    assign err       = r_err;
    assign set_hour  = r_set_hour;
    assign set_min   = r_set_min;
    assign set_sec   = r_set_sec;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_cmd_parser
//  Purpose  : Directed self-checking bench for uart_cmd_parser. Runs a
//             vector table of single-cycle byte/expected-output records,
//             then sequences for timeout, the expiry race and mid-sentence
//             reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_parser;

    localparam int unsigned c_timeout = 16;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [3:0] cmd_btn;
    logic [2:0] cmd_tog;
    logic       set_valid;
    logic [4:0] set_hour;
    logic [5:0] set_min;
    logic [5:0] set_sec;
    logic       err;

    uart_cmd_parser #(
        .TIMEOUT_CYC (c_timeout)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .cmd_btn   (cmd_btn),
        .cmd_tog   (cmd_tog),
        .set_valid (set_valid),
        .set_hour  (set_hour),
        .set_min   (set_min),
        .set_sec   (set_sec),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [3:0] btn;
        logic [2:0] tog;
        logic       sv;
        logic       er;
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic [4:0] cur_h = 5'd0;
    logic [5:0] cur_m = 6'd0;
    logic [5:0] cur_s = 6'd0;

    // Present one cycle of inputs, then sample just after the edge
    task automatic step(input logic r, input logic v, input logic [7:0] d);
        @(negedge clk);
        rst      = r;
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] btn, input logic [2:0] tog,
                         input logic sv, input logic er);
        logic [25:0] got, exp;
        got = {cmd_btn, cmd_tog, set_valid, err, set_hour, set_min, set_sec};
        exp = {btn, tog, sv, er, cur_h, cur_m, cur_s};
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got btn=%b tog=%b sv=%b err=%b t=%0d:%0d:%0d, expected btn=%b tog=%b sv=%b err=%b t=%0d:%0d:%0d",
                     name, cmd_btn, cmd_tog, set_valid, err, set_hour, set_min, set_sec,
                     btn, tog, sv, er, cur_h, cur_m, cur_s);
        end
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic [3:0] btn,
                       input logic [2:0] tog, input logic sv, input logic er);
        vec_t x;
        x.v = v; x.d = d; x.btn = btn; x.tog = tog; x.sv = sv; x.er = er;
        x.h = cur_h; x.m = cur_m; x.s = cur_s;
        vecs.push_back(x);
    endtask

    // Command byte followed by two quiet cycles
    task automatic cmd(input logic [7:0] d, input logic [3:0] btn, input logic [2:0] tog);
        add(1'b1, d, btn, tog, 1'b0, 1'b0);
        add(1'b0, 8'h00, 4'b0, 3'b0, 1'b0, 1'b0);
        add(1'b0, 8'h00, 4'b0, 3'b0, 1'b0, 1'b0);
    endtask

    // Back-to-back bytes that produce no output activity
    task automatic quiet(input string str);
        for (int i = 0; i < str.len(); i++) begin
            add(1'b1, 8'(str[i]), 4'b0, 3'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic idle();
        add(1'b0, 8'h00, 4'b0, 3'b0, 1'b0, 1'b0);
    endtask

    task automatic send_quiet(input string tag, input string str);
        for (int i = 0; i < str.len(); i++) begin
            step(1'b0, 1'b1, 8'(str[i]));
            check(tag, 4'b0, 3'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        // ---------------- vector table ----------------
        cmd("r", 4'b1000, 3'b000);
        cmd("L", 4'b0100, 3'b000);
        cmd("+", 4'b0010, 3'b000);
        cmd("-", 4'b0001, 3'b000);
        cmd("F", 4'b0000, 3'b100);
        cmd("M", 4'b0000, 3'b010);
        cmd("C", 4'b0000, 3'b001);
        cmd("s", 4'b1000, 3'b000);
        cmd("R", 4'b1000, 3'b000);
        cmd("c", 4'b0100, 3'b000);
        cmd("z", 4'b0000, 3'b000);
        add(1'b1, "L", 4'b0100, 3'b000, 1'b0, 1'b0);
        add(1'b1, "-", 4'b0001, 3'b000, 1'b0, 1'b0);
        idle();
        quiet("T123456");
        cur_h = 5'd12; cur_m = 6'd34; cur_s = 6'd56;
        add(1'b1, 8'h0D, 4'b0, 3'b0, 1'b1, 1'b0);
        idle();
        quiet("T240000");
        add(1'b1, 8'h0A, 4'b0, 3'b0, 1'b0, 1'b1);
        idle();
        quiet("T1");
        add(1'b1, "x", 4'b0, 3'b0, 1'b0, 1'b1);
        add(1'b1, "r", 4'b1000, 3'b0, 1'b0, 1'b0);
        idle();
        quiet("T12");
        add(1'b1, "r", 4'b0, 3'b0, 1'b0, 1'b1);
        idle();
        quiet("T006000");
        add(1'b1, 8'h0D, 4'b0, 3'b0, 1'b0, 1'b1);
        quiet("T000060");
        add(1'b1, 8'h0D, 4'b0, 3'b0, 1'b0, 1'b1);
        quiet("T123456");
        add(1'b1, "x", 4'b0, 3'b0, 1'b0, 1'b1);
        quiet("T");
        add(1'b1, "T", 4'b0, 3'b0, 1'b0, 1'b1);
        quiet("T000000");
        cur_h = 5'd0; cur_m = 6'd0; cur_s = 6'd0;
        add(1'b1, 8'h0A, 4'b0, 3'b0, 1'b1, 1'b0);
        quiet("T235959");
        cur_h = 5'd23; cur_m = 6'd59; cur_s = 6'd59;
        add(1'b1, 8'h0D, 4'b0, 3'b0, 1'b1, 1'b0);
        idle();

        // ---------------- reset state ----------------
        cur_h = 5'd0; cur_m = 6'd0; cur_s = 6'd0;
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, "r");
        check("reset", 4'b0, 3'b0, 1'b0, 1'b0);

        // ---------------- table ----------------
        foreach (vecs[i]) begin
            step(1'b0, vecs[i].v, vecs[i].d);
            cur_h = vecs[i].h; cur_m = vecs[i].m; cur_s = vecs[i].s;
            check($sformatf("vec%0d", i), vecs[i].btn, vecs[i].tog, vecs[i].sv, vecs[i].er);
        end

        // ---------------- timeout with silence ----------------
        send_quiet("to_bytes", "T09");
        for (int j = 1; j < 16; j++) begin
            step(1'b0, 1'b0, 8'h00);
            check($sformatf("to_quiet%0d", j), 4'b0, 3'b0, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 8'h00);
        check("to_expire", 4'b0, 3'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, "r");
        check("to_idle", 4'b1000, 3'b0, 1'b0, 1'b0);

        // ---------------- byte arriving in the expiry cycle ----------------
        send_quiet("race_bytes", "T09");
        for (int j = 1; j < 16; j++) begin
            step(1'b0, 1'b0, 8'h00);
            check($sformatf("race_quiet%0d", j), 4'b0, 3'b0, 1'b0, 1'b0);
        end
        step(1'b0, 1'b1, "1");
        check("race_byte", 4'b0, 3'b0, 1'b0, 1'b0);
        send_quiet("race_tail", "234");
        step(1'b0, 1'b1, 8'h0D);
        cur_h = 5'd9; cur_m = 6'd12; cur_s = 6'd34;
        check("race_set", 4'b0, 3'b0, 1'b1, 1'b0);

        // ---------------- reset mid-sentence ----------------
        send_quiet("rst_pre", "T01");
        step(1'b1, 1'b1, "5");
        cur_h = 5'd0; cur_m = 6'd0; cur_s = 6'd0;
        check("rst_mid", 4'b0, 3'b0, 1'b0, 1'b0);
        send_quiet("rst_post", "23\r");
        step(1'b0, 1'b1, "r");
        check("rst_after", 4'b1000, 3'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
